// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
//
// Groups the three buses of the fetch stage into one bundle:
//   - instruction memory request/ack bus (imem_*)
//   - redirect pulse from the datapath (redirect_*)
//   - instruction delivery valid/ready bus (inst_*)
//
// Modports:
//   master : the fetch unit side (drives imem_req/addr and inst_*)
//   slave  : the environment side (memory + datapath)
// ----------------------------------------------------------------------------
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );

endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Sequential instruction fetch stage. Issues one word fetch at a time to
// instruction memory, buffers returned words with their PCs in a DEPTH-entry
// FIFO and hands them to the datapath over valid/ready. A redirect flushes
// the FIFO and restarts fetching at the new target; a fetch that is still
// in flight at redirect time is completed against its old address and its
// data thrown away (DROP mode).
//
// Parameters:
//   DEPTH    : FIFO entries, power of two, >= 2
//   RESET_PC : first fetch address after reset
//
// Ports:
//   clk   : clock, all state updates on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch_unit_if.master (imem_*, redirect_*, inst_*)
//
// Mode FSM:
//   state      | meaning
//   -----------+---------------------------------------------------------
//   MODE_FETCH | normal fetching; acked words are pushed into the FIFO
//   MODE_DROP  | waiting out an in-flight fetch at the pre-redirect address;
//              | its ack is consumed and the data discarded
// ----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {
    MODE_FETCH = 1'b0,
    MODE_DROP  = 1'b1
  } mode_t;

  mode_t         r_mode;
  mode_t         w_mode_nxt;

  // Low for the reset cycle so imem_req stays quiet until the first clock
  // after reset release, without taking a combinational path from rst_n.
  logic          r_run;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_drop_addr;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];

  logic          w_full;
  logic          w_req;
  logic          w_fire;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_pc;

  // The request only looks at registered state. In FETCH a raised request
  // cannot drop before its ack because the count can only fall (pop) while
  // it is waiting.
  assign w_full        = (r_count == FULL_CNT);
  assign w_req         = r_run && ((r_mode == MODE_DROP) || !w_full);
  assign w_fire        = w_req && bus.imem_ack;
  assign w_push        = (r_mode == MODE_FETCH) && w_fire && !bus.redirect_valid;
  assign w_pop         = (r_count != '0) && bus.inst_ready;
  assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = (r_mode == MODE_DROP) ? r_drop_addr : r_fetch_pc;
  assign bus.inst_valid = (r_count != '0);
  assign bus.inst_data  = r_fifo_data[r_rd_ptr];
  assign bus.inst_pc    = r_fifo_pc[r_rd_ptr];

  // --------------------------------------------------------------------------
  // Mode FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_FETCH;
      r_run  <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_run  <= 1'b1;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      MODE_FETCH: begin
        // Only an unacked outstanding request needs to be waited out.
        if (bus.redirect_valid && w_req && !bus.imem_ack) begin
          w_mode_nxt = MODE_DROP;
        end
      end
      MODE_DROP: begin
        // Request is always high here; a further redirect only moves the
        // target, the pending ack still ends the drop.
        if (bus.imem_ack) begin
          w_mode_nxt = MODE_FETCH;
        end
      end
      default: w_mode_nxt = MODE_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch PC, drop address, FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc  <= RESET_PC;
      r_drop_addr <= RESET_PC;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_fifo_pc[i]   <= 32'h0;
        r_fifo_data[i] <= 32'h0;
      end
    end else if (bus.redirect_valid) begin
      // Flush wins over any same-cycle push or pop. A pop in this cycle is
      // still taken by the datapath; it just has no effect on our state.
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fetch_pc <= w_redirect_pc;
      // Keep the address of the request on the bus if we are about to wait
      // it out; in DROP the held address must not move.
      if (r_mode == MODE_FETCH) begin
        r_drop_addr <= r_fetch_pc;
      end
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
        r_fifo_data[r_wr_ptr] <= bus.imem_rdata;
        r_wr_ptr              <= r_wr_ptr + AW'(1);
        r_fetch_pc            <= r_fetch_pc + 32'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
